mips_bus_ram: RTL and testbench

Synthesizable memory slave on the mips_cpu_bus memory port. It turns the CPU's read/write/byteenable requests into word accesses on an internal RAM, and asserts waitrequest for a configurable number of stall cycles. It replaces the behavioural RAM in the top-level system and in the instruction-level testbenches. It supports byte lanes, out-of-window detection and the address-0 halt convention.

---
 rtl/mips_bus_ram.sv | 85 ++++++++
 tb/tb_mips_bus_ram.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_ram.sv
// Memory slave for the mips_cpu_bus data/instruction port: word-organised RAM with
// byte lanes, configurable wait states, range checking and the address-0 halt read.
module mips_bus_ram #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic        bus_error
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] WINDOW   = 33'(longint'(DEPTH) * 4);
    localparam logic [3:0]  WAIT_LIM = 4'(WAIT_CYCLES);

    logic [31:0]   mem [DEPTH];
    logic [3:0]    cnt;
    logic          req;
    logic          accept;
    logic [31:0]   offset;
    logic          in_range;
    logic [AW-1:0] idx;
    logic [31:0]   word;
    logic [31:0]   lane_word;
    logic          do_write;
    logic          do_read;
    logic          access_bad;

    assign req      = read | write;
    // cnt never exceeds WAIT_LIM because it only advances while stalled,
    // so "not yet at the limit" is the same as "below the limit".
    assign waitrequest = req && (cnt != WAIT_LIM);
    assign accept   = req && !waitrequest;

    assign offset   = address - BASE_ADDR;
    assign in_range = ({1'b0, offset} < WINDOW) && (address[1:0] == 2'b00);
    assign idx      = offset[AW+1:2];
    assign word     = mem[idx];

    assign do_write = accept && write && !read && in_range;
    assign do_read  = accept && read && !write && in_range && (address != 32'h0);
    // Address 0 is the CPU halt fetch, so a plain read there is never an error.
    assign access_bad = (read && write) ||
                        (!in_range && !(read && !write && address == 32'h0));

    // Memory is big-endian: bus lane k lives in word bits [31-8k:24-8k].
    always_comb begin
        lane_word = '0;
        for (int k = 0; k < 4; k++) begin
            if (byteenable[k]) lane_word[8*k +: 8] = word[24-8*k +: 8];
        end
    end

    assign readdata = (reset && do_read) ? lane_word : 32'h0;

    // A write whose commit edge sees reset low is dropped; contents survive reset.
    always_ff @(posedge clk) begin
        if (reset && do_write) begin
            for (int k = 0; k < 4; k++) begin
                if (byteenable[k]) mem[idx][24-8*k +: 8] <= writedata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= 4'd0;
            bus_error <= 1'b0;
        end else begin
            if (waitrequest) cnt <= cnt + 4'd1;
            else             cnt <= 4'd0;
            if (accept && access_bad) bus_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_bus_ram.sv
// Directed bench for mips_bus_ram: three instances with 0, 2 and 3 wait states,
// a table of single accesses plus hand sequences for reset corner cases.
module tb_mips_bus_ram;

    localparam logic [31:0] B = 32'hBFC00000;
    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        read_s  [NDUT];
    logic        write_s [NDUT];
    logic [31:0] addr_s  [NDUT];
    logic [3:0]  be_s    [NDUT];
    logic [31:0] wd_s    [NDUT];
    logic [31:0] rd_s    [NDUT];
    logic        wait_s  [NDUT];
    logic        err_s   [NDUT];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int WC = (g == 0) ? 0 : (g == 1) ? 2 : 3;
        mips_bus_ram #(.BASE_ADDR(B), .DEPTH(16), .WAIT_CYCLES(WC), .INIT_FILE("")) u_dut (
            .clk(clk), .reset(reset), .address(addr_s[g]), .read(read_s[g]),
            .write(write_s[g]), .byteenable(be_s[g]), .writedata(wd_s[g]),
            .readdata(rd_s[g]), .waitrequest(wait_s[g]), .bus_error(err_s[g])
        );
    end

    typedef struct {
        int          d;
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          exp_st;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Inputs already driven; wait for the accept cycle, then let its edge commit.
    task automatic wait_accept(input int d, output logic [31:0] rdata, output int stalls,
                               output logic nz);
        stalls = 0;
        nz = 1'b0;
        rdata = 'x;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!wait_s[d]) begin
                rdata = rd_s[d];
                break;
            end
            if (rd_s[d] !== 32'h0) nz = 1'b1;
            stalls++;
        end
        @(posedge clk);
        #1;
        read_s[d] = 1'b0;
        write_s[d] = 1'b0;
    endtask

    task automatic access(input int d, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd,
                          output logic [31:0] rdata, output int stalls, output logic nz);
        read_s[d] = rd;
        write_s[d] = wr;
        addr_s[d] = a;
        be_s[d] = be;
        wd_s[d] = wd;
        wait_accept(d, rdata, stalls, nz);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdata;
        int stalls;
        logic nz;

        for (int d = 0; d < NDUT; d++) begin
            read_s[d] = 1'b0; write_s[d] = 1'b0; addr_s[d] = 32'h0;
            be_s[d] = 4'h0; wd_s[d] = 32'h0;
        end

        vecs.push_back('{1, 1'b0, 1'b1, B + 8,  4'b1111, 32'hDEADBEEF, 32'h0,        2, 1'b0});
        vecs.push_back('{1, 1'b1, 1'b0, B + 8,  4'b1111, 32'h0,        32'hDEADBEEF, 2, 1'b0});
        vecs.push_back('{1, 1'b0, 1'b1, B + 4,  4'b1111, 32'h0,        32'h0,        2, 1'b0});
        vecs.push_back('{1, 1'b0, 1'b1, B + 4,  4'b0010, 32'hAABBCCDD, 32'h0,        2, 1'b0});
        vecs.push_back('{1, 1'b1, 1'b0, B + 4,  4'b1111, 32'h0,        32'h0000CC00, 2, 1'b0});
        vecs.push_back('{1, 1'b1, 1'b0, B + 4,  4'b0010, 32'h0,        32'h0000CC00, 2, 1'b0});
        vecs.push_back('{1, 1'b1, 1'b0, B + 8,  4'b0101, 32'h0,        32'h00AD00EF, 2, 1'b0});
        vecs.push_back('{1, 1'b0, 1'b1, B + 12, 4'b1111, 32'h11223344, 32'h0,        2, 1'b0});
        vecs.push_back('{1, 1'b0, 1'b1, B + 12, 4'b1001, 32'hFFFFFFFF, 32'h0,        2, 1'b0});
        vecs.push_back('{1, 1'b1, 1'b0, B + 12, 4'b1111, 32'h0,        32'hFF2233FF, 2, 1'b0});
        vecs.push_back('{0, 1'b0, 1'b1, B,      4'b1111, 32'h44332211, 32'h0,        0, 1'b0});
        vecs.push_back('{0, 1'b1, 1'b0, B,      4'b1111, 32'h0,        32'h44332211, 0, 1'b0});
        vecs.push_back('{0, 1'b1, 1'b0, 32'h0,  4'b1111, 32'h0,        32'h0,        0, 1'b0});
        vecs.push_back('{0, 1'b0, 1'b1, B + 60, 4'b1111, 32'hCAFEF00D, 32'h0,        0, 1'b0});
        vecs.push_back('{0, 1'b1, 1'b0, B + 60, 4'b1111, 32'h0,        32'hCAFEF00D, 0, 1'b0});
        vecs.push_back('{0, 1'b1, 1'b0, B + 64, 4'b1111, 32'h0,        32'h0,        0, 1'b1});
        vecs.push_back('{0, 1'b1, 1'b0, B,      4'b1111, 32'h0,        32'h44332211, 0, 1'b1});
        vecs.push_back('{1, 1'b0, 1'b1, B + 9,  4'b1111, 32'h12345678, 32'h0,        2, 1'b1});
        vecs.push_back('{1, 1'b1, 1'b0, B + 8,  4'b1111, 32'h0,        32'hDEADBEEF, 2, 1'b1});
        vecs.push_back('{2, 1'b0, 1'b1, B,      4'b1111, 32'h01020304, 32'h0,        3, 1'b0});
        vecs.push_back('{2, 1'b1, 1'b1, B,      4'b1111, 32'hFFFFFFFF, 32'h0,        3, 1'b1});
        vecs.push_back('{2, 1'b1, 1'b0, B,      4'b1111, 32'h0,        32'h01020304, 3, 1'b1});

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("reset_wait_d%0d", d), 32'(wait_s[d]), 32'h0);
            check($sformatf("reset_rdata_d%0d", d), rd_s[d], 32'h0);
            check($sformatf("reset_err_d%0d", d), 32'(err_s[d]), 32'h0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            access(vecs[i].d, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].be, vecs[i].wd,
                   rdata, stalls, nz);
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rd);
            check($sformatf("v%0d_stalls", i), 32'(stalls), 32'(vecs[i].exp_st));
            check($sformatf("v%0d_err", i), 32'(err_s[vecs[i].d]), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_stall_rdata", i), 32'(nz), 32'h0);
        end

        // Asynchronous reset mid-cycle clears every sticky error without a clock edge.
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++)
            check($sformatf("async_reset_err_d%0d", d), 32'(err_s[d]), 32'h0);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        access(2, 1'b1, 1'b0, B, 4'b1111, 32'h0, rdata, stalls, nz);
        check("mem_kept_after_reset", rdata, 32'h01020304);
        check("err_clear_after_reset", 32'(err_s[2]), 32'h0);

        // Reset asserted after one stall cycle restarts the full stall count.
        read_s[2] = 1'b1; write_s[2] = 1'b0; addr_s[2] = B; be_s[2] = 4'b1111;
        @(negedge clk);
        check("midstall_first_wait", 32'(wait_s[2]), 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        wait_accept(2, rdata, stalls, nz);
        check("midstall_restart_stalls", 32'(stalls), 32'd3);
        check("midstall_restart_rdata", rdata, 32'h01020304);

        // A write accepted on an edge that sees reset low is dropped.
        read_s[0] = 1'b0; write_s[0] = 1'b1; addr_s[0] = B; be_s[0] = 4'b1111;
        wd_s[0] = 32'hBAD0BAD0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        write_s[0] = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        access(0, 1'b1, 1'b0, B, 4'b1111, 32'h0, rdata, stalls, nz);
        check("write_dropped_in_reset", rdata, 32'h44332211);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
